// File: rtl/rv32m_mul_issue.sv
// Core-side issue/retire sequencer for the RV32M multiply datapath (MUL/MULH/MULHSU/MULHU).
// Optional zero-operand bypass enabled by defining RV32M_MUL_ZERO_BYPASS_EN.
module rv32m_mul_issue (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [2:0]  req_funct3_i,
   input  logic [31:0] req_rs1_i,
   input  logic [31:0] req_rs2_i,
   input  logic [4:0]  req_rd_i,
   output logic        mult_en_o,
   output logic        mult_rst_o,
   output logic [31:0] mult_a_o,
   output logic [31:0] mult_b_o,
   input  logic        mult_done_i,
   input  logic [63:0] mult_product_i,
   output logic        resp_valid_o,
   input  logic        resp_ready_i,
   output logic [31:0] resp_data_o,
   output logic [4:0]  resp_rd_o
);

   typedef enum logic [1:0] {IDLE, RUN, CLEAR, RESP} state_t;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;

   state_t      r_state;
   state_t      w_nextState;
   logic [2:0]  r_funct3;
   logic [4:0]  r_rd;
   logic [31:0] r_magA;
   logic [31:0] r_magB;
   logic        r_neg;
   logic [63:0] r_product;

   logic        w_accept;
   logic        w_aSigned;
   logic        w_bSigned;
   logic [31:0] w_magA;
   logic [31:0] w_magB;
   logic        w_neg;
   logic        w_zeroOp;
   logic [63:0] w_corrected;

   assign w_accept  = req_valid_i && (r_state == IDLE);
   assign w_aSigned = (req_funct3_i == F3_MULH) || (req_funct3_i == F3_MULHSU);
   assign w_bSigned = (req_funct3_i == F3_MULH);
   assign w_magA    = (w_aSigned && req_rs1_i[31]) ? (~req_rs1_i + 32'd1) : req_rs1_i;
   assign w_magB    = (w_bSigned && req_rs2_i[31]) ? (~req_rs2_i + 32'd1) : req_rs2_i;
   assign w_neg     = (req_funct3_i == F3_MULH)   ? (req_rs1_i[31] ^ req_rs2_i[31]) :
                      (req_funct3_i == F3_MULHSU) ? req_rs1_i[31] : 1'b0;

`ifdef RV32M_MUL_ZERO_BYPASS_EN
   assign w_zeroOp = (req_rs1_i == 32'd0) || (req_rs2_i == 32'd0);
`else
   assign w_zeroOp = 1'b0;
`endif

   // The multiplier only ever sees magnitudes, so the sign is restored here on capture.
   assign w_corrected = r_neg ? (~mult_product_i + 64'd1) : mult_product_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_nextState = w_zeroOp ? RESP : RUN;
         RUN:     if (mult_done_i) w_nextState = CLEAR;
         CLEAR:   w_nextState = RESP;
         RESP:    if (resp_ready_i) w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // Operand magnitudes stay on the multiplier inputs until the next accept.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_funct3  <= 3'd0;
         r_rd      <= 5'd0;
         r_magA    <= 32'd0;
         r_magB    <= 32'd0;
         r_neg     <= 1'b0;
         r_product <= 64'd0;
      end else if (w_accept) begin
         r_funct3  <= req_funct3_i;
         r_rd      <= req_rd_i;
         r_magA    <= w_magA;
         r_magB    <= w_magB;
         r_neg     <= w_neg;
         r_product <= 64'd0;
      end else if ((r_state == RUN) && mult_done_i) begin
         r_product <= w_corrected;
      end
   end

   always_comb begin
      req_ready_o  = (r_state == IDLE);
      mult_en_o    = (r_state == RUN);
      mult_rst_o   = rst_i || (r_state == CLEAR);
      mult_a_o     = r_magA;
      mult_b_o     = r_magB;
      resp_valid_o = (r_state == RESP);
      resp_data_o  = (r_funct3 == F3_MUL) ? r_product[31:0] : r_product[63:32];
      resp_rd_o    = r_rd;
   end

endmodule

// File: tb/tb_rv32m_mul_issue.sv
// Self-checking bench for rv32m_mul_issue: directed timing/backpressure/reset cases plus
// randomized operations against an arithmetic reference model and a variable-latency multiplier.
module tb_rv32m_mul_issue;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic [2:0]  req_funct3_i = 3'd0;
   logic [31:0] req_rs1_i = 32'd0;
   logic [31:0] req_rs2_i = 32'd0;
   logic [4:0]  req_rd_i = 5'd0;
   logic        mult_en_o;
   logic        mult_rst_o;
   logic [31:0] mult_a_o;
   logic [31:0] mult_b_o;
   logic        mult_done_i;
   logic [63:0] mult_product_i;
   logic        resp_valid_o;
   logic        resp_ready_i = 1'b1;
   logic [31:0] resp_data_o;
   logic [4:0]  resp_rd_o;

   int errors = 0;
   int checks = 0;

   int          mLat = 6;
   int          mCnt = 0;
   logic        mDone = 1'b0;
   logic [63:0] mProd = 64'd0;

   logic [31:0] expData;
   logic [4:0]  expRd;
   logic [31:0] expA;
   logic [31:0] expB;
   int          expLat;
   int          expEn;
   int          expRst;

   rv32m_mul_issue dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .req_valid_i    (req_valid_i),
      .req_ready_o    (req_ready_o),
      .req_funct3_i   (req_funct3_i),
      .req_rs1_i      (req_rs1_i),
      .req_rs2_i      (req_rs2_i),
      .req_rd_i       (req_rd_i),
      .mult_en_o      (mult_en_o),
      .mult_rst_o     (mult_rst_o),
      .mult_a_o       (mult_a_o),
      .mult_b_o       (mult_b_o),
      .mult_done_i    (mult_done_i),
      .mult_product_i (mult_product_i),
      .resp_valid_o   (resp_valid_o),
      .resp_ready_i   (resp_ready_i),
      .resp_data_o    (resp_data_o),
      .resp_rd_o      (resp_rd_o)
   );

   always #5 clk_i = ~clk_i;

   // Unsigned multiplier model: done rises mLat edges after enable rises, sticky until cleared.
   always @(posedge clk_i) begin
      if (mult_rst_o) begin
         mCnt  <= 0;
         mDone <= 1'b0;
         mProd <= 64'd0;
      end else if (mult_en_o && !mDone) begin
         if (mCnt == mLat - 1) begin
            mDone <= 1'b1;
            mProd <= {32'd0, mult_a_o} * {32'd0, mult_b_o};
         end
         mCnt <= mCnt + 1;
      end
   end

   assign mult_done_i    = mDone;
   assign mult_product_i = mDone ? mProd : 64'hDEADBEEF_CAFEF00D;

   function automatic logic [31:0] refResult(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
      longint      sa;
      longint      sb;
      longint      p;
      logic [63:0] up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      up = {32'd0, a} * {32'd0, b};
      case (f3)
         3'd0: return up[31:0];
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
         default: return up[63:32];
      endcase
   endfunction

   function automatic logic [31:0] refMag(input logic [31:0] x, input logic isSigned);
      longint v;
      v = isSigned ? longint'($signed(x)) : longint'({32'd0, x});
      if (v < 0) v = -v;
      return v[31:0];
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic computeExpect(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] rd);
      logic bypass;
      bypass = 1'b0;
`ifdef RV32M_MUL_ZERO_BYPASS_EN
      bypass = (a == 32'd0) || (b == 32'd0);
`endif
      expData = refResult(f3, a, b);
      expRd   = rd;
      expA    = refMag(a, (f3 == 3'd1) || (f3 == 3'd2));
      expB    = refMag(b, (f3 == 3'd1));
      expLat  = bypass ? 1 : mLat + 3;
      expEn   = bypass ? 0 : mLat + 1;
      expRst  = bypass ? 0 : 1;
   endtask

   // Called #1 after a clock edge; returns #1 after the accepting edge (T+1).
   task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] rd);
      bit done;
      int waited;
      done = 0;
      waited = 0;
      req_funct3_i = f3;
      req_rs1_i    = a;
      req_rs2_i    = b;
      req_rd_i     = rd;
      req_valid_i  = 1'b1;
      while (!done && waited < 20) begin
         if (req_ready_o) done = 1;
         @(posedge clk_i);
         #1;
         waited++;
      end
      if (!done) checkOutput("accept", 0, 1);
      req_valid_i = 1'b0;
      computeExpect(f3, a, b, rd);
   endtask

   task automatic waitResp();
      int cyc;
      int enCnt;
      int rstCnt;
      int rstCyc;
      cyc = 1;
      enCnt = 0;
      rstCnt = 0;
      rstCyc = -1;
      while (!resp_valid_o && cyc < 60) begin
         if (cyc == 1) begin
            checkOutput("magA", mult_a_o, expA);
            checkOutput("magB", mult_b_o, expB);
         end
         if (mult_en_o) enCnt++;
         if (mult_rst_o) begin
            rstCnt++;
            rstCyc = cyc;
         end
         @(posedge clk_i);
         #1;
         cyc++;
      end
      checkOutput("latency", cyc, expLat);
      checkOutput("enCycles", enCnt, expEn);
      checkOutput("clrCycles", rstCnt, expRst);
      if (rstCnt > 0) checkOutput("clrCycle", rstCyc, expLat - 1);
      checkOutput("data", resp_data_o, expData);
      checkOutput("rd", resp_rd_o, expRd);
   endtask

   // Called #1 after RESP entry; holds resp_ready low for 'hold' cycles, then retires.
   task automatic finishResp(input int hold);
      if (hold > 0) resp_ready_i = 1'b0;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk_i);
         #1;
         checkOutput("bpValid", resp_valid_o, 1);
         checkOutput("bpData", resp_data_o, expData);
         checkOutput("bpRd", resp_rd_o, expRd);
         checkOutput("bpReqReady", req_ready_o, 0);
         checkOutput("bpEn", mult_en_o, 0);
      end
      resp_ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      checkOutput("retireValid", resp_valid_o, 0);
      checkOutput("retireReady", req_ready_o, 1);
   endtask

   task automatic runOp(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int hold);
      applyStimulus(f3, a, b, rd);
      waitResp();
      finishResp(hold);
   endtask

   function automatic logic [31:0] pickOperand();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int vCount;

      rst_i = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;
      checkOutput("rstReqReady", req_ready_o, 1);
      checkOutput("rstMultRst", mult_rst_o, 1);
      checkOutput("rstEn", mult_en_o, 0);
      checkOutput("rstValid", resp_valid_o, 0);
      checkOutput("rstData", resp_data_o, 0);
      checkOutput("rstRd", resp_rd_o, 0);
      checkOutput("rstA", mult_a_o, 0);
      checkOutput("rstB", mult_b_o, 0);
      rst_i = 1'b0;
      #1;
      checkOutput("idleMultRst", mult_rst_o, 0);
      @(posedge clk_i);
      #1;

      $display("[TB] directed operations");
      runOp(3'd0, 32'd7, 32'd6, 5'd5, 0);
      runOp(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 0);
      runOp(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 0);
      runOp(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 0);
      runOp(3'd2, 32'hFFFF_FFFE, 32'd3, 5'd4, 0);
      runOp(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6, 0);

      $display("[TB] backpressure with a pending request");
      applyStimulus(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 5'd9);
      waitResp();
      req_funct3_i = 3'd1;
      req_rs1_i    = 32'hFFFF_FFF0;
      req_rs2_i    = 32'd100;
      req_rd_i     = 5'd10;
      req_valid_i  = 1'b1;
      finishResp(5);
      @(posedge clk_i);
      #1;
      checkOutput("heldAccept", req_ready_o, 0);
      req_valid_i = 1'b0;
      computeExpect(3'd1, 32'hFFFF_FFF0, 32'd100, 5'd10);
      waitResp();
      finishResp(0);

      $display("[TB] reset during RUN");
      applyStimulus(3'd0, 32'd10, 32'd20, 5'd7);
      repeat (3) @(posedge clk_i);
      #1;
      rst_i = 1'b1;
      #1;
      checkOutput("midRstEn", mult_en_o, 0);
      checkOutput("midRstReqReady", req_ready_o, 1);
      checkOutput("midRstMultRst", mult_rst_o, 1);
      checkOutput("midRstA", mult_a_o, 0);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      vCount = 0;
      for (int i = 0; i < 15; i++) begin
         if (resp_valid_o) vCount++;
         @(posedge clk_i);
         #1;
      end
      checkOutput("droppedResp", vCount, 0);
      runOp(3'd0, 32'd3, 32'd5, 5'd11, 0);

      $display("[TB] zero operand");
      runOp(3'd0, 32'd0, 32'd9, 5'd12, 0);

      $display("[TB] randomized operations");
      for (int n = 0; n < 40; n++) begin
         mLat = $urandom_range(1, 8);
         runOp(3'($urandom_range(0, 7)), pickOperand(), pickOperand(),
               5'($urandom_range(0, 31)), $urandom_range(0, 3));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
